// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes 40-bit serdes packets into parameter-bus
// reads/writes with an ack timeout, and builds the response word for the serdes.
module spi_cmd_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dataReady,
  input  logic [39:0]           inPacket,
  output logic [39:0]           outPacket,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [3:0]  OP_NOP    = 4'h0;
  localparam logic [3:0]  OP_WRITE  = 4'h1;
  localparam logic [3:0]  OP_READ   = 4'h2;
  localparam logic [3:0]  OP_STATUS = 4'h3;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t                state_q, state_d;
  logic [15:0]           cmd_q, cmd_d;        // {opcode, address}
  logic [23:0]           rsp_q, rsp_d;        // response data field
  logic                  err_q, err_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [7:0]            pkt_q, pkt_d;
  logic [7:0]            ov_q, ov_d;
  logic [7:0]            to_q, to_d;
  logic [39:0]           out_q, out_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  busy_q;

  // Next-state, counters and registered bus/response outputs
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    wait_d  = wait_q;
    pkt_d   = pkt_q;
    ov_d    = ov_q;
    to_d    = to_q;
    out_d   = out_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;

    if (dataReady) begin
      pkt_d = pkt_q + 8'd1;
      if (state_q != IDLE && ov_q != 8'hFF) ov_d = ov_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (dataReady) begin
          cmd_d  = inPacket[39:24];
          wait_d = '0;
          err_d  = 1'b0;
          rsp_d  = '0;
          case (inPacket[39:36])
            OP_WRITE: begin
              state_d = WR;
              we_d    = 1'b1;
              addr_d  = ADDR_WIDTH'(inPacket[35:24]);
              wdata_d = DATA_WIDTH'(inPacket[23:0]);
              rsp_d   = inPacket[23:0];
            end
            OP_READ: begin
              state_d = RD;
              re_d    = 1'b1;
              addr_d  = ADDR_WIDTH'(inPacket[35:24]);
            end
            OP_NOP, OP_STATUS: state_d = RESP;
            default: begin
              state_d = RESP;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      WR, RD: begin
        // An ack on the timeout cycle still wins
        if (mem_ack) begin
          if (state_q == RD) rsp_d = 24'(mem_rdata);
          state_d = RESP;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rsp_d   = '0;
          if (to_q != 8'hFF) to_d = to_q + 8'd1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          we_d   = (state_q == WR);
          re_d   = (state_q == RD);
        end
      end
      RESP: begin
        out_d = {err_q, cmd_q[14:12], cmd_q[11:0],
                 (cmd_q[15:12] == OP_STATUS) ? {ov_q, to_q, pkt_q} : rsp_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      pkt_q   <= '0;
      ov_q    <= '0;
      to_q    <= '0;
      out_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      pkt_q   <= pkt_d;
      ov_q    <= ov_d;
      to_q    <= to_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign outPacket = out_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: write, read, timeout, overflow, illegal and reset cases.
module tb_spi_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dataReady = 1'b0;
  logic [39:0] inPacket = '0;
  logic [39:0] outPacket;
  logic [11:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [23:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cnt;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(24), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .dataReady(dataReady), .inPacket(inPacket),
    .outPacket(outPacket), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [39:0] p);
    dataReady = 1'b1;
    inPacket  = p;
    step();
    dataReady = 1'b0;
    inPacket  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_out",   outPacket, 40'h0);
    check("rst_we",    40'(mem_we), 40'h0);
    check("rst_re",    40'(mem_re), 40'h0);
    check("rst_addr",  40'(mem_addr), 40'h0);
    check("rst_wdata", 40'(mem_wdata), 40'h0);
    check("rst_busy",  40'(busy), 40'h0);
    rst_n = 1'b1;
    step();

    // WRITE with ack in the third WR cycle
    send(40'h100A123456);
    check("wr_we1",    40'(mem_we), 40'h1);
    check("wr_re",     40'(mem_re), 40'h0);
    check("wr_addr",   40'(mem_addr), 40'h00A);
    check("wr_wdata",  40'(mem_wdata), 40'h123456);
    check("wr_busy",   40'(busy), 40'h1);
    step();
    check("wr_we2",    40'(mem_we), 40'h1);
    step();
    check("wr_we3",    40'(mem_we), 40'h1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("wr_we_drop", 40'(mem_we), 40'h0);
    check("wr_out_old", outPacket, 40'h0);
    step();
    check("wr_out",    outPacket, 40'h100A123456);
    check("wr_idle",   40'(busy), 40'h0);
    step();
    check("wr_out_hold", outPacket, 40'h100A123456);

    // READ
    send(40'h2005000000);
    check("rd_re",     40'(mem_re), 40'h1);
    check("rd_we",     40'(mem_we), 40'h0);
    check("rd_addr",   40'(mem_addr), 40'h005);
    mem_rdata = 24'hABCDEF;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 24'h0;
    check("rd_re_drop", 40'(mem_re), 40'h0);
    step();
    check("rd_out",    outPacket, 40'h2005ABCDEF);

    // ILLEGAL opcode 0x7
    send(40'h70ABFFFFFF);
    check("ill_we",    40'(mem_we), 40'h0);
    check("ill_re",    40'(mem_re), 40'h0);
    check("ill_addr",  40'(mem_addr), 40'h005);
    check("ill_busy",  40'(busy), 40'h1);
    step();
    check("ill_out",   outPacket, 40'hF0AB000000);

    // STATUS: 4 packets, no overflow/timeout
    send(40'h3000000000);
    step();
    check("st1_out",   outPacket, 40'h3000000004);

    // READ timeout
    send(40'h2005000000);
    cnt = 0;
    while (mem_re === 1'b1 && cnt < 400) begin
      cnt++;
      step();
    end
    check("to_re_cycles", 40'(cnt), 40'd255);
    check("to_busy",   40'(busy), 40'h1);
    step();
    check("to_out",    outPacket, 40'hA005000000);
    send(40'h3000000000);
    step();
    check("st2_out",   outPacket, 40'h3000000106);

    // Ack on the final cycle before timeout counts as success
    send(40'h2005000000);
    repeat (254) step();
    check("edge_re_last", 40'(mem_re), 40'h1);
    mem_rdata = 24'h55AA55;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 24'h0;
    check("edge_re_drop", 40'(mem_re), 40'h0);
    step();
    check("edge_out",  outPacket, 40'h200555AA55);
    send(40'h3000000000);
    step();
    check("st3_out",   outPacket, 40'h3000000108);

    // Reset, then overflow while in RD
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_out",  outPacket, 40'h0);
    check("rst2_busy", 40'(busy), 40'h0);
    send(40'h2005000000);
    send(40'h100A123456);
    check("ov_re",     40'(mem_re), 40'h1);
    check("ov_we",     40'(mem_we), 40'h0);
    mem_rdata = 24'h000111;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 24'h0;
    step();
    check("ov_rd_out", outPacket, 40'h2005000111);
    send(40'h3000000000);
    // Packet arriving as RESP returns to IDLE is dropped
    send(40'h100A123456);
    check("ov_st_out", outPacket, 40'h3000010003);
    check("resp_drop_busy", 40'(busy), 40'h0);
    check("resp_drop_we",   40'(mem_we), 40'h0);
    send(40'h3000000000);
    step();
    check("ov_st2_out", outPacket, 40'h3000020005);

    // Reset mid-WR, dataReady ignored during reset, late ack ignored
    send(40'h100A123456);
    step();
    check("mwr_we",    40'(mem_we), 40'h1);
    rst_n     = 1'b0;
    dataReady = 1'b1;
    inPacket  = 40'h3000000000;
    step();
    rst_n     = 1'b1;
    dataReady = 1'b0;
    inPacket  = '0;
    check("mwr_we_rst",   40'(mem_we), 40'h0);
    check("mwr_busy_rst", 40'(busy), 40'h0);
    check("mwr_addr_rst", 40'(mem_addr), 40'h0);
    check("mwr_wd_rst",   40'(mem_wdata), 40'h0);
    check("mwr_out_rst",  outPacket, 40'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("mwr_ack_we",   40'(mem_we), 40'h0);
    check("mwr_ack_busy", 40'(busy), 40'h0);
    step();
    check("mwr_ack_out",  outPacket, 40'h0);
    send(40'h3000000000);
    step();
    check("mwr_st_out",   outPacket, 40'h3000000001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the parameter-bus address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 24, meaning the parameter-bus data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ack.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have the port dataReady, input, 1 bit: a one-cycle pulse from the SPI serdes meaning a packet has completed.
REQ-007 The block SHALL have the port inPacket, input, 40 bits: the received packet, valid while dataReady=1.
REQ-008 The block SHALL have the port outPacket, output, 40 bits: the response word, which the serdes samples when dataReady=1.
REQ-009 The block SHALL have the port mem_addr, output, ADDR_WIDTH bits: the parameter-bus address.
REQ-010 The block SHALL have the port mem_wdata, output, DATA_WIDTH bits: the parameter-bus write data.
REQ-011 The block SHALL have the port mem_we, output, 1 bit: the write request.
REQ-012 The block SHALL have the port mem_re, output, 1 bit: the read request.
REQ-013 The block SHALL have the port mem_rdata, input, DATA_WIDTH bits: the read data, valid when mem_ack=1.
REQ-014 The block SHALL have the port mem_ack, input, 1 bit: the bus completion, a one-cycle pulse.
REQ-015 The block SHALL have the port busy, output, 1 bit: high while the state is not IDLE.

Function
REQ-016 The packet format SHALL be: [39:36] opcode, [35:24] address, [23:0] data.
REQ-017 The opcodes SHALL be: 0x0 NOP, 0x1 WRITE, 0x2 READ, 0x3 STATUS; every other opcode is ILLEGAL.
REQ-018 The state machine SHALL have the states IDLE, WR, RD and RESP.
REQ-019 In IDLE with dataReady=1, the block SHALL capture inPacket into a command register and increment pkt_cnt (8 bits, wraps at 255 to 0).
REQ-020 The transition from IDLE on capture SHALL go to WR for WRITE, to RD for READ, and to RESP for NOP, STATUS or ILLEGAL.
REQ-021 In WR, the block SHALL hold mem_we=1 with mem_addr and mem_wdata from the command until mem_ack, then go to RESP.
REQ-022 In RD, the block SHALL hold mem_re=1 with mem_addr until mem_ack, capture mem_rdata on that cycle, then go to RESP.
REQ-023 mem_we and mem_re SHALL never both be 1; mem_we, mem_re, mem_addr and mem_wdata SHALL be registered.
REQ-024 In WR or RD, a wait counter SHALL increment each cycle without mem_ack.
REQ-025 When the wait counter reaches TIMEOUT, the block SHALL drop the request, set err, increment to_cnt (8 bits, saturating at 255) and go to RESP.
REQ-026 mem_ack arriving on the same cycle as the timeout SHALL count as success, with no timeout recorded.
REQ-027 In RESP, the block SHALL load outPacket for exactly one cycle, then return to IDLE.
REQ-028 The response SHALL be [39] err, [38:36] opcode[2:0], [35:24] address echo, and [23:0] data.
REQ-029 The response data field SHALL be: WRITE = the written data echo; READ = the read data, or 0 on timeout; STATUS = {ov_cnt, to_cnt, pkt_cnt}; NOP = 0; ILLEGAL = 0.
REQ-030 err SHALL be 1 for ILLEGAL commands and for timeouts, and 0 otherwise.
REQ-031 outPacket SHALL hold its value between RESP loads.
REQ-032 Because the serdes preloads at the end of each packet, the response to packet N SHALL be shifted out during packet N+2.
REQ-033 On dataReady=1 while busy, the packet SHALL be dropped, ov_cnt (8 bits, saturating) SHALL increment, and pkt_cnt SHALL still increment.
REQ-034 On dataReady=1 in the same cycle RESP returns to IDLE, the packet SHALL be dropped as busy.
REQ-035 The counters SHALL be read-only; reading STATUS SHALL NOT clear them.
REQ-036 The STATUS response SHALL report pkt_cnt including the STATUS packet itself.

Reset
REQ-037 With rst_n=0 at a clk edge, the state SHALL become IDLE, the command register and wait counter SHALL clear, and an in-flight bus request SHALL be abandoned.
REQ-038 With rst_n=0 at a clk edge, outPacket, mem_addr, mem_wdata, mem_we, mem_re, busy, pkt_cnt, ov_cnt and to_cnt SHALL all become 0.
REQ-039 During rst_n=0, dataReady SHALL be ignored.
REQ-040 Outputs SHALL change only on clk edges, including entry into and exit from reset.

Verification
REQ-041 The bench SHALL cover WRITE: inPacket=0x1_00A_123456 with mem_ack 3 cycles later -> mem_we=1 for 3 cycles with addr 0x00A and data 0x123456, then outPacket=0x1_00A_123456.
REQ-042 The bench SHALL cover READ: inPacket=0x2_005_000000 with mem_rdata=0xABCDEF at ack -> outPacket=0x2_005_ABCDEF.
REQ-043 The bench SHALL cover timeout: READ with no ack -> mem_re drops after 255 cycles, outPacket=0xA_005_000000, and to_cnt=1.
REQ-044 The bench SHALL cover overflow: a second dataReady while in RD -> the packet is dropped, and a following STATUS returns ov_cnt=1 with pkt_cnt=3.
REQ-045 The bench SHALL cover ILLEGAL: opcode 0x7 -> outPacket=0xF_addr_000000 with no bus activity.
REQ-046 The bench SHALL cover reset mid-WR: rst_n=0 for 1 cycle -> mem_we=0 and all counters 0 next cycle, and a later mem_ack is ignored.
